uart_rx_ms: RTL and testbench

Parametrised next-generation UART receiver with configurable oversampling ratio and three-sample majority voting per bit. It adds false-start rejection, noise detection, one or two stop bits, and a one-entry output holding register with valid/ready handshake and overrun detection. It sits between the UART pin synchroniser/baud divider and the RX FIFO of the UART peripheral.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_rx_sampler.sv | 46 ++++
 rtl/uart_rx_ms.sv | 163 ++++++++++++++++
 tb/tb_uart_rx_ms.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types: word length, receiver error flags and receiver FSM states.
package uart_pkg;

  typedef enum logic [1:0] {
    WordLen5,
    WordLen6,
    WordLen7,
    WordLen8
  } word_len_e;

  typedef struct packed {
    logic break_int;
    logic frame_err;
    logic parity_err;
    logic noise_err;
    logic overrun_err;
  } rx_err_ms_s;

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
    RxParity,
    RxStop,
    RxStop2
  } rx_ms_state_e;

  // Data is shifted in from the MSB end; move a short word down to bit 0.
  function automatic logic [7:0] right_justify(logic [7:0] sh, word_len_e wl);
    return sh >> (3'd3 - {1'b0, wl});
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Oversampling tick counter with three-sample majority vote around the bit centre.
module uart_rx_sampler #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic div_clk_en,
  input  logic run,
  input  logic clear,
  input  logic rxs,
  output logic bit_val,
  output logic bit_noise,
  output logic bit_done
);

  localparam int unsigned M    = OVERSAMPLE / 2;
  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam logic [CntW-1:0] TickLast = CntW'(OVERSAMPLE - 1);
  localparam logic [CntW-1:0] TickPre  = CntW'(M - 1);
  localparam logic [CntW-1:0] TickMid  = CntW'(M);
  localparam logic [CntW-1:0] TickPost = CntW'(M + 1);

  logic [CntW-1:0] cnt_q;
  logic            s0_q;
  logic            s1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      s0_q  <= 1'b1;
      s1_q  <= 1'b1;
    end else if (clear || !run) begin
      cnt_q <= '0;
    end else if (div_clk_en) begin
      cnt_q <= (cnt_q == TickLast) ? '0 : cnt_q + 1'b1;
      if (cnt_q == TickPre) s0_q <= rxs;
      if (cnt_q == TickMid) s1_q <= rxs;
    end
  end

  // Third sample is the live line value on the deciding tick.
  assign bit_done  = run & ~clear & div_clk_en & (cnt_q == TickPost);
  assign bit_val   = (s0_q & s1_q) | (s0_q & rxs) | (s1_q & rxs);
  assign bit_noise = ~((s0_q == s1_q) && (s1_q == rxs));

endmodule

// File: rtl/uart_rx_ms.sv
// UART receiver: majority-voted oversampling, parity/stop checks, one-entry holding register.
module uart_rx_ms
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       div_clk_en,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output rx_err_ms_s rx_err,
  input  word_len_e  cfg_word_len,
  input  logic       cfg_parity_en,
  input  logic       cfg_even_parity,
  input  logic       cfg_force_parity,
  input  logic       cfg_two_stop
);

  logic rx_meta_q, rxs_q, rxs_prev_q;

  // Two-flop synchroniser plus one stage for edge detection; idle line is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rx_meta_q  <= rx;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  rx_ms_state_e state_q;
  word_len_e    wl_q;
  logic         par_en_q, even_q, force_q, two_stop_q;
  logic [2:0]   bit_cnt_q;
  logic [7:0]   shift_q;
  logic         par_acc_q, par_err_q, noise_q, zero_q;

  logic       start_det;
  logic       bit_val, bit_noise, bit_done;
  logic       complete;
  rx_err_ms_s new_err;

  assign start_det = (state_q == RxIdle) & rxs_prev_q & ~rxs_q;

  uart_rx_sampler #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_sampler (
    .clk       (clk),
    .rst       (rst),
    .div_clk_en(div_clk_en),
    .run       (state_q != RxIdle),
    .clear     (start_det),
    .rxs       (rxs_q),
    .bit_val   (bit_val),
    .bit_noise (bit_noise),
    .bit_done  (bit_done)
  );

  // A zero first stop bit ends the frame at once, even with two stop bits configured.
  always_comb begin
    complete = 1'b0;
    if (bit_done) begin
      if (state_q == RxStop)  complete = ~bit_val | ~two_stop_q;
      if (state_q == RxStop2) complete = 1'b1;
    end
    new_err.break_int   = zero_q & ~bit_val;
    new_err.frame_err   = ~bit_val;
    new_err.parity_err  = par_err_q;
    new_err.noise_err   = noise_q | bit_noise;
    new_err.overrun_err = rx_valid & ~rx_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RxIdle;
      wl_q       <= WordLen8;
      par_en_q   <= 1'b0;
      even_q     <= 1'b0;
      force_q    <= 1'b0;
      two_stop_q <= 1'b0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_acc_q  <= 1'b0;
      par_err_q  <= 1'b0;
      noise_q    <= 1'b0;
      zero_q     <= 1'b0;
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      rx_err     <= '0;
    end else begin
      if (complete) begin
        rx_valid <= 1'b1;
        rx_data  <= right_justify(shift_q, wl_q);
        rx_err   <= new_err;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      unique case (state_q)
        RxIdle: begin
          if (start_det) begin
            wl_q       <= cfg_word_len;
            par_en_q   <= cfg_parity_en;
            even_q     <= cfg_even_parity;
            force_q    <= cfg_force_parity;
            two_stop_q <= cfg_two_stop;
            state_q    <= RxStart;
          end
        end
        RxStart: begin
          if (bit_done) begin
            if (bit_val) begin
              state_q <= RxIdle;
            end else begin
              state_q   <= RxData;
              bit_cnt_q <= '0;
              par_acc_q <= 1'b0;
              par_err_q <= 1'b0;
              noise_q   <= bit_noise;
              zero_q    <= 1'b1;
            end
          end
        end
        RxData: begin
          if (bit_done) begin
            shift_q   <= {bit_val, shift_q[7:1]};
            par_acc_q <= par_acc_q ^ bit_val;
            noise_q   <= noise_q | bit_noise;
            zero_q    <= zero_q & ~bit_val;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == {1'b1, wl_q}) state_q <= par_en_q ? RxParity : RxStop;
          end
        end
        RxParity: begin
          if (bit_done) begin
            par_err_q <= force_q ? (bit_val != ~even_q) : (bit_val != (par_acc_q ^ ~even_q));
            noise_q   <= noise_q | bit_noise;
            zero_q    <= zero_q & ~bit_val;
            state_q   <= RxStop;
          end
        end
        RxStop: begin
          if (bit_done) begin
            noise_q <= noise_q | bit_noise;
            zero_q  <= zero_q & ~bit_val;
            state_q <= complete ? RxIdle : RxStop2;
          end
        end
        RxStop2: begin
          if (bit_done) state_q <= RxIdle;
        end
        default: state_q <= RxIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ms.sv
// Directed bench for uart_rx_ms with a scoreboard of expected frames.
module tb_uart_rx_ms;
  import uart_pkg::*;

  localparam int Os  = 16;
  localparam int M   = Os / 2;
  localparam int Div = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       div_clk_en;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  rx_err_ms_s rx_err;
  word_len_e  cfg_word_len = WordLen8;
  logic       cfg_parity_en = 1'b0;
  logic       cfg_even_parity = 1'b0;
  logic       cfg_force_parity = 1'b0;
  logic       cfg_two_stop = 1'b0;

  int div_cnt = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [7:0] data;
    rx_err_ms_s err;
  } exp_s;

  exp_s sb[$];

  uart_rx_ms #(.OVERSAMPLE(Os)) dut (
    .clk             (clk),
    .rst             (rst),
    .rx              (rx),
    .div_clk_en      (div_clk_en),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .rx_data         (rx_data),
    .rx_err          (rx_err),
    .cfg_word_len    (cfg_word_len),
    .cfg_parity_en   (cfg_parity_en),
    .cfg_even_parity (cfg_even_parity),
    .cfg_force_parity(cfg_force_parity),
    .cfg_two_stop    (cfg_two_stop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) div_cnt <= (div_cnt == Div - 1) ? 0 : div_cnt + 1;
  assign div_clk_en = (div_cnt == 0);

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  function automatic rx_err_ms_s mk_err(logic brk, logic fe, logic pe, logic ne, logic oe);
    rx_err_ms_s e;
    e.break_int   = brk;
    e.frame_err   = fe;
    e.parity_err  = pe;
    e.noise_err   = ne;
    e.overrun_err = oe;
    return e;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Return #1 after the next clock edge on which div_clk_en is sampled high.
  task automatic tick_rdy(input logic pulse);
    @(negedge clk);
    while (!div_clk_en) @(negedge clk);
    if (pulse) rx_ready = 1'b1;
    @(posedge clk);
    #1;
    if (pulse) rx_ready = 1'b0;
  endtask

  task automatic tick();
    tick_rdy(1'b0);
  endtask

  task automatic drive_bit(input logic v, input int flip_t, input int pulse_t);
    for (int t = 0; t < Os; t++) begin
      rx = (t == flip_t) ? ~v : v;
      tick_rdy(t == pulse_t);
    end
  endtask

  // Frame: start, nbits data LSB first, optional parity, stop1=1, optional stop2.
  task automatic send_frame(input logic [7:0] d, input int nbits, input logic par_en,
                            input logic par_bit, input logic stop2_en, input logic stop2,
                            input int flip_bit, input logic pulse_done);
    logic bits[0:11];
    int n = 0;
    bits[n++] = 1'b0;
    for (int i = 0; i < nbits; i++) bits[n++] = d[i];
    if (par_en) bits[n++] = par_bit;
    bits[n++] = 1'b1;
    if (stop2_en) bits[n++] = stop2;
    tick();
    for (int i = 0; i < n; i++)
      drive_bit(bits[i], (i == flip_bit) ? M - 1 : -1, (pulse_done && i == n - 1) ? M + 1 : -1);
    drive_bit(1'b1, -1, -1);
  endtask

  task automatic send_8n1(input logic [7:0] d);
    send_frame(d, 8, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
  endtask

  task automatic expect_frame(input string tag);
    exp_s e;
    int n = 0;
    @(negedge clk);
    while (!rx_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, {7'd0, rx_valid}, 8'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 8'd0, 8'(sb.size() + 1));
    end else begin
      e = sb.pop_front();
      check({tag, "_data"}, rx_data, e.data);
      check({tag, "_err"}, {3'd0, rx_err}, {3'd0, e.err});
    end
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    @(negedge clk);
    check({tag, "_valid_fall"}, {7'd0, rx_valid}, 8'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", {7'd0, rx_valid}, 8'd0);
    check("rst_data", rx_data, 8'h00);
    check("rst_err", {3'd0, rx_err}, 8'h00);

    // 8N1 basic frame
    sb.push_back('{data: 8'hA5, err: mk_err(0, 0, 0, 0, 0)});
    send_8n1(8'hA5);
    expect_frame("8n1_a5");

    // 7E2 with wrong parity bit (correct even parity of 0x35 over 7 bits is 0)
    cfg_word_len = WordLen7;
    cfg_parity_en = 1'b1;
    cfg_even_parity = 1'b1;
    cfg_two_stop = 1'b1;
    sb.push_back('{data: 8'h35, err: mk_err(0, 0, 1, 0, 0)});
    send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1, 1'b1, -1, 1'b0);
    expect_frame("7e2_bad_par");

    // 7E2, correct parity, second stop bit low
    sb.push_back('{data: 8'h35, err: mk_err(0, 1, 0, 0, 0)});
    send_frame(8'h35, 7, 1'b1, 1'b0, 1'b1, 1'b0, -1, 1'b0);
    expect_frame("7e2_stop2");

    // Short glitch is rejected as a false start
    cfg_word_len = WordLen8;
    cfg_parity_en = 1'b0;
    cfg_even_parity = 1'b0;
    cfg_two_stop = 1'b0;
    tick();
    rx = 1'b0;
    repeat (6) tick();
    rx = 1'b1;
    repeat (2 * Os) tick();
    @(negedge clk);
    check("glitch_no_valid", {7'd0, rx_valid}, 8'd0);
    sb.push_back('{data: 8'h5A, err: mk_err(0, 0, 0, 0, 0)});
    send_8n1(8'h5A);
    expect_frame("after_glitch");

    // One corrupted sample at tick M-1 of data bit 3
    sb.push_back('{data: 8'h3C, err: mk_err(0, 0, 0, 1, 0)});
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b0);
    expect_frame("noise");

    // Overrun: two frames with no read in between
    send_8n1(8'h11);
    sb.push_back('{data: 8'h22, err: mk_err(0, 0, 0, 0, 1)});
    send_8n1(8'h22);
    expect_frame("overrun");

    // Read coincides with the completion cycle: no overrun
    send_8n1(8'h11);
    sb.push_back('{data: 8'h33, err: mk_err(0, 0, 0, 0, 0)});
    send_frame(8'h33, 8, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b1);
    expect_frame("read_at_done");

    // Line held low for two frame times gives exactly one break frame
    sb.push_back('{data: 8'h00, err: mk_err(1, 1, 0, 0, 0)});
    tick();
    rx = 1'b0;
    repeat (20 * Os) tick();
    rx = 1'b1;
    repeat (Os) tick();
    expect_frame("break");
    repeat (2 * Os) tick();
    @(negedge clk);
    check("break_single", {7'd0, rx_valid}, 8'd0);

    // Reset in the middle of a frame with an unread frame pending
    send_8n1(8'h77);
    @(negedge clk);
    check("pre_rst_valid", {7'd0, rx_valid}, 8'd1);
    tick();
    drive_bit(1'b0, -1, -1);
    drive_bit(1'b1, -1, -1);
    drive_bit(1'b1, -1, -1);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midrst_valid", {7'd0, rx_valid}, 8'd0);
    check("midrst_data", rx_data, 8'h00);
    check("midrst_err", {3'd0, rx_err}, 8'h00);
    rst = 1'b0;
    repeat (9) drive_bit(1'b1, -1, -1);
    @(negedge clk);
    check("midrst_no_frame", {7'd0, rx_valid}, 8'd0);
    check("sb_drained", 8'(sb.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
